// File: rtl/vga_text_fetch.sv
// rtl/vga_text_fetch.sv - text-mode character fetch and pixel serialiser for the VGA path
module vga_text_fetch #(
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int BLINK_BIT   = 5,
  parameter int CURSOR_ROW0 = 14
) (
  input  logic        pix_clk,
  input  logic        rst_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        active_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [11:0] txt_addr,
  input  logic [7:0]  txt_data,
  output logic [10:0] rom_addr,
  output logic        rom_en,
  input  logic [15:0] rom_do,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  input  logic        cursor_en,
  input  logic [11:0] fg_color,
  input  logic [11:0] bg_color,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_out
);

  localparam logic SYNC_IDLE = ~SYNC_ACTIVE;

  // Cell coordinates of the incoming pixel
  logic [6:0]  cell_col;
  logic [4:0]  cell_row;
  logic [3:0]  glyph_row_in;
  logic [11:0] addr_next;
  logic        cursor_hit_in;

  logic [5:0]  frame_cnt;
  logic        vsync_prev;

  // Glyph row travels with the text RAM read; pixel index and cursor wait for the ROM read
  logic [3:0]       glyph_d1;
  logic [3:0]       glyph_d2;
  logic             inv_d3;
  logic             inv_d4;
  logic [3:0][2:0]  pix_d;
  logic [3:0]       cursor_d;
  logic [3:0]       hs_d;
  logic [3:0]       vs_d;
  logic [3:0]       act_d;

  logic [7:0]  glyph_byte;
  logic        pix_bit;
  logic        pixel_on;
  logic        unused_bits;

  assign cell_col     = hcount[9:3];
  assign cell_row     = vcount[8:4];
  assign glyph_row_in = vcount[3:0];

  // row*80 built from two shifts so no multiplier is needed
  assign addr_next = {1'b0, cell_row, 6'b0} + {3'b0, cell_row, 4'b0} + {5'b0, cell_col};

  assign cursor_hit_in = cursor_en
                       & (cell_col == cursor_col)
                       & (cell_row == cursor_row)
                       & (glyph_row_in >= 4'(CURSOR_ROW0))
                       & frame_cnt[BLINK_BIT];

  // Leftmost pixel is bit 7, so index 7-pix which for 3 bits is the bitwise inverse
  assign glyph_byte = rom_do[7:0];
  assign pix_bit    = glyph_byte[~pix_d[3]];
  assign pixel_on   = (pix_bit ^ inv_d4) | cursor_d[3];

  // The upper ROM byte and the top row bit carry no information for 80x30 text
  assign unused_bits = ^{rom_do[15:8], vcount[9]};

  // Frame counter steps once at the leading edge of each vsync pulse
  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      vsync_prev <= SYNC_IDLE;
      frame_cnt  <= '0;
    end else begin
      vsync_prev <= vsync_in;
      if ((vsync_in == SYNC_ACTIVE) && (vsync_prev != SYNC_ACTIVE)) begin
        frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end

  // Text RAM address, then char_rom address once the character code returns
  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      txt_addr <= '0;
      glyph_d1 <= '0;
      glyph_d2 <= '0;
      rom_addr <= '0;
      inv_d3   <= 1'b0;
      inv_d4   <= 1'b0;
      rom_en   <= 1'b0;
    end else begin
      txt_addr <= addr_next;
      glyph_d1 <= glyph_row_in;
      glyph_d2 <= glyph_d1;
      rom_addr <= {txt_data[6:0], glyph_d2};
      inv_d3   <= txt_data[7];
      inv_d4   <= inv_d3;
      rom_en   <= 1'b1;
    end
  end

  // Delay lines matching the two external read latencies plus our two address stages
  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      pix_d    <= '0;
      cursor_d <= '0;
      hs_d     <= {4{SYNC_IDLE}};
      vs_d     <= {4{SYNC_IDLE}};
      act_d    <= '0;
    end else begin
      pix_d    <= {pix_d[2:0], hcount[2:0]};
      cursor_d <= {cursor_d[2:0], cursor_hit_in};
      hs_d     <= {hs_d[2:0], hsync_in};
      vs_d     <= {vs_d[2:0], vsync_in};
      act_d    <= {act_d[2:0], active_in};
    end
  end

  // Output register: colour select with blanking, syncs aligned to the same edge
  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      rgb        <= '0;
      hsync_out  <= SYNC_IDLE;
      vsync_out  <= SYNC_IDLE;
      active_out <= 1'b0;
    end else begin
      if (!act_d[3]) begin
        rgb <= '0;
      end else if (pixel_on) begin
        rgb <= fg_color;
      end else begin
        rgb <= bg_color;
      end
      hsync_out  <= hs_d[3];
      vsync_out  <= vs_d[3];
      active_out <= act_d[3];
    end
  end

endmodule

// File: tb/tb_vga_text_fetch.sv
// tb/tb_vga_text_fetch.sv - directed checks of the text fetch pipeline
module tb_vga_text_fetch;

  logic        pix_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  hcount = 10'd700;
  logic [9:0]  vcount = 10'd0;
  logic        active_in = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [11:0] txt_addr;
  logic [7:0]  txt_data = 8'h00;
  logic [10:0] rom_addr;
  logic        rom_en;
  logic [15:0] rom_do = 16'h0000;
  logic [6:0]  cursor_col = 7'd0;
  logic [4:0]  cursor_row = 5'd0;
  logic        cursor_en = 1'b0;
  logic [11:0] fg_color = 12'hF00;
  logic [11:0] bg_color = 12'h00F;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic        active_out;

  logic [7:0]  txt_mem [0:4095];
  logic [15:0] rom_mem [0:2047];

  logic [11:0] e_rgb [0:799];
  logic        e_hs  [0:799];
  logic        e_act [0:799];

  int n_checks = 0;
  int n_errors = 0;

  vga_text_fetch dut (
    .pix_clk    (pix_clk),
    .rst_n      (rst_n),
    .hcount     (hcount),
    .vcount     (vcount),
    .active_in  (active_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .txt_addr   (txt_addr),
    .txt_data   (txt_data),
    .rom_addr   (rom_addr),
    .rom_en     (rom_en),
    .rom_do     (rom_do),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .cursor_en  (cursor_en),
    .fg_color   (fg_color),
    .bg_color   (bg_color),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .active_out (active_out)
  );

  always #5 pix_clk = ~pix_clk;

  // Registered-read models of the text buffer RAM and char_rom
  always @(posedge pix_clk) begin
    txt_data <= txt_mem[txt_addr];
    if (rom_en) rom_do <= rom_mem[rom_addr];
  end

  task automatic step();
    @(negedge pix_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One active pixel surrounded by idle cycles; checks each stage at its own edge
  task automatic probe(input string tag, input logic [9:0] h, input logic [9:0] v, input logic act,
                       input logic [11:0] e_addr, input logic [10:0] e_rom, input logic [11:0] e_pix);
    hcount = h; vcount = v; active_in = act;
    step();
    hcount = 10'd700; active_in = 1'b0;
    check({tag, ".txt_addr"}, 32'(txt_addr), 32'(e_addr));
    step(); step();
    check({tag, ".rom_addr"}, 32'(rom_addr), 32'(e_rom));
    step();
    check({tag, ".rgb_early"}, 32'(rgb), 32'h0);
    step();
    check({tag, ".rgb"}, 32'(rgb), 32'(e_pix));
  endtask

  task automatic vsync_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      vsync_in = 1'b0; step(); step();
      vsync_in = 1'b1; step();
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) txt_mem[a] = 8'h00;
    for (int a = 0; a < 2048; a++) rom_mem[a] = 16'h0000;

    // Reset with active/hsync asserted on the inputs
    rst_n = 1'b0; active_in = 1'b1; hsync_in = 1'b0;
    step(); step(); step();
    check("rst.rgb", 32'(rgb), 32'h0);
    check("rst.hsync_out", 32'(hsync_out), 32'h1);
    check("rst.vsync_out", 32'(vsync_out), 32'h1);
    check("rst.rom_en", 32'(rom_en), 32'h0);
    check("rst.txt_addr", 32'(txt_addr), 32'h0);
    check("rst.active_out", 32'(active_out), 32'h0);
    rst_n = 1'b1;
    step();
    check("rel.rom_en", 32'(rom_en), 32'h1);
    step(); step(); step();
    check("rel.active_out_c4", 32'(active_out), 32'h0);
    check("rel.hsync_out_c4", 32'(hsync_out), 32'h1);
    step();
    check("rel.active_out_c5", 32'(active_out), 32'h1);
    check("rel.hsync_out_c5", 32'(hsync_out), 32'h0);
    active_in = 1'b0; hsync_in = 1'b1;
    repeat (6) step();

    // Address path, pixel select and inverse attribute
    txt_mem[162] = 8'h41;
    rom_mem[11'h413] = 16'h0081;
    probe("addr.px0", 10'd16, 10'd35, 1'b1, 12'd162, 11'h413, 12'hF00);
    probe("addr.px1", 10'd17, 10'd35, 1'b1, 12'd162, 11'h413, 12'h00F);
    probe("addr.px7", 10'd23, 10'd35, 1'b1, 12'd162, 11'h413, 12'hF00);
    txt_mem[162] = 8'hC1;
    probe("inv.px0", 10'd16, 10'd35, 1'b1, 12'd162, 11'h413, 12'h00F);
    probe("inv.px1", 10'd17, 10'd35, 1'b1, 12'd162, 11'h413, 12'hF00);

    // Blanking and ignored upper ROM byte
    txt_mem[162] = 8'h41;
    rom_mem[11'h413] = 16'h00FF;
    probe("blank.off", 10'd16, 10'd35, 1'b0, 12'd162, 11'h413, 12'h000);
    probe("blank.on", 10'd16, 10'd35, 1'b1, 12'd162, 11'h413, 12'hF00);
    rom_mem[11'h413] = 16'hFF00;
    probe("hibyte", 10'd16, 10'd35, 1'b1, 12'd162, 11'h413, 12'h00F);

    // Full-line sweep: sync/active alignment and bit order across many cells
    for (int c = 0; c < 100; c++) begin
      txt_mem[c] = 8'(c);
      rom_mem[11'(c * 16 + 5)] = 16'((c * 37 + 11) & 255);
    end
    vcount = 10'd5;
    for (int i = 0; i < 805; i++) begin
      if (i >= 5) begin
        check("sweep.rgb", 32'(rgb), 32'(e_rgb[i-5]));
        check("sweep.hsync_out", 32'(hsync_out), 32'(e_hs[i-5]));
        check("sweep.active_out", 32'(active_out), 32'(e_act[i-5]));
      end
      if (i < 800) begin
        logic [7:0] b;
        b = 8'(((i / 8) * 37 + 11) & 255);
        hcount = 10'(i);
        active_in = (i < 640);
        hsync_in = !((i >= 656) && (i < 752));
        e_act[i] = (i < 640);
        e_hs[i] = hsync_in;
        e_rgb[i] = (i < 640) ? (b[7 - (i % 8)] ? 12'hF00 : 12'h00F) : 12'h000;
      end else begin
        hcount = 10'd700; active_in = 1'b0; hsync_in = 1'b1;
      end
      step();
    end
    repeat (4) step();

    // Cursor underline and blink phase
    txt_mem[162] = 8'h05;
    cursor_col = 7'd2; cursor_row = 5'd2; cursor_en = 1'b1;
    probe("cur.phase0", 10'd16, 10'd46, 1'b1, 12'd162, 11'h05E, 12'h00F);
    vsync_pulses(32);
    probe("cur.on_px0", 10'd16, 10'd46, 1'b1, 12'd162, 11'h05E, 12'hF00);
    probe("cur.on_px7", 10'd23, 10'd46, 1'b1, 12'd162, 11'h05E, 12'hF00);
    probe("cur.row15", 10'd16, 10'd47, 1'b1, 12'd162, 11'h05F, 12'hF00);
    probe("cur.row13", 10'd16, 10'd45, 1'b1, 12'd162, 11'h05D, 12'h00F);
    probe("cur.next_col", 10'd24, 10'd46, 1'b1, 12'd163, 11'h00E, 12'h00F);
    cursor_en = 1'b0;
    probe("cur.disabled", 10'd16, 10'd46, 1'b1, 12'd162, 11'h05E, 12'h00F);
    cursor_en = 1'b1;
    vsync_pulses(32);
    probe("cur.phase64", 10'd16, 10'd46, 1'b1, 12'd162, 11'h05E, 12'h00F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
